// File: rtl/md_unit_if.sv
// Handshake and result bundle between the E-stage control and the multiply/divide unit.
interface md_unit_if;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A;
   logic [31:0] B;
   logic        flush;
   logic        busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] out;

   modport master (output start, op, A, B, flush, input busy, HI, LO, out);
   modport slave  (input start, op, A, B, flush, output busy, HI, LO, out);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO; the result is computed at issue
// and committed after a fixed busy window so stall timing matches the real pipeline.
module md_unit #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input logic       clk,
   input logic       reset,
   md_unit_if.slave  md
);
   localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MTHI  = 3'd4;
   localparam logic [2:0] OP_MTLO  = 3'd5;
   localparam logic [2:0] OP_MFHI  = 3'd6;
   localparam logic [2:0] OP_MFLO  = 3'd7;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic [31:0]        hi_q, hi_d, lo_q, lo_d;
   logic [31:0]        hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
   logic               dz_q, dz_d;
   logic               accept;
   logic               is_mul, is_div;
   logic [63:0]        mul_res, div_res;
   logic [31:0]        out_c;

   function automatic logic [63:0] mul_full(input logic [31:0] a, input logic [31:0] b,
                                            input logic is_signed);
      logic signed [63:0] sa, sb;
      logic [63:0]        ua, ub;
      logic [63:0]        p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      if (is_signed) p = 64'(sa * sb);
      else           p = ua * ub;
      return p;
   endfunction

   // Returns {remainder, quotient}; signed case works on magnitudes so that
   // 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
   function automatic logic [63:0] div_full(input logic [31:0] a, input logic [31:0] b,
                                            input logic is_signed);
      logic        neg_a, neg_b;
      logic [31:0] ua, ub, q, r;
      neg_a = is_signed & a[31];
      neg_b = is_signed & b[31];
      ua = neg_a ? (32'd0 - a) : a;
      ub = neg_b ? (32'd0 - b) : b;
      if (ub == 32'd0) ub = 32'd1;
      q = ua / ub;
      r = ua % ub;
      if (neg_a ^ neg_b) q = 32'd0 - q;
      if (neg_a)         r = 32'd0 - r;
      return {r, q};
   endfunction

   assign accept  = md.start & ~md.flush & ~busy_q;
   assign is_mul  = (md.op == OP_MULT) | (md.op == OP_MULTU);
   assign is_div  = (md.op == OP_DIV)  | (md.op == OP_DIVU);
   assign mul_res = mul_full(md.A, md.B, md.op == OP_MULT);
   assign div_res = div_full(md.A, md.B, md.op == OP_DIV);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         dz_q    <= dz_d;
      end
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (accept && (is_mul || is_div)) begin
               state_d = S_RUN;
               cnt_d   = is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
            end
         end
         S_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_d   = busy_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      hi_tmp_d = hi_tmp_q;
      lo_tmp_d = lo_tmp_q;
      dz_d     = dz_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_mul) begin
                  busy_d   = 1'b1;
                  dz_d     = 1'b0;
                  hi_tmp_d = mul_res[63:32];
                  lo_tmp_d = mul_res[31:0];
               end else if (is_div) begin
                  busy_d   = 1'b1;
                  dz_d     = (md.B == 32'd0);
                  hi_tmp_d = div_res[63:32];
                  lo_tmp_d = div_res[31:0];
               end else if (md.op == OP_MTHI) begin
                  hi_d = md.A;
               end else if (md.op == OP_MTLO) begin
                  lo_d = md.A;
               end
            end
         end
         S_RUN: begin
            if (cnt_q == CNT_W'(1)) begin
               busy_d = 1'b0;
               if (!dz_q) begin
                  hi_d = hi_tmp_q;
                  lo_d = lo_tmp_q;
               end
            end
         end
         default: busy_d = 1'b0;
      endcase
      case (md.op)
         OP_MFHI: out_c = hi_q;
         OP_MFLO: out_c = lo_q;
         default: out_c = 32'd0;
      endcase
   end

   assign md.busy = busy_q;
   assign md.HI   = hi_q;
   assign md.LO   = lo_q;
   assign md.out  = out_c;
endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit with its own sequencing controller, located in the E stage of the P7 pipeline.
- Executes mult/multu/div/divu over a fixed number of cycles, and mthi/mtlo in a single cycle.
- Holds the HI/LO registers and supplies mfhi/mflo data.
- Exports `busy`; the D-stage stall logic holds any MD-class instruction in D while `busy` or `start` is high.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (must be ≥1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be ≥1).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  E-stage instruction is an MD op this cycle
- op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
- A  input  32  rs operand (forwarded)
- B  input  32  rt operand (forwarded)
- flush  input  1  exception/eret cancel of the E-stage instruction this cycle
- busy  output  1  multi-cycle operation in progress (registered)
- HI  output  32  HI register
- LO  output  32  LO register
- out  output  32  mfhi/mflo read data (combinational)

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE, counter=0, busy=0, HI=0, LO=0.
  - Any in-flight operation is discarded and its result is never written.
- accept = start & ~flush & ~busy.
  - `start` while busy=1 is ignored; upstream must never issue it, and the bench checks that it has no effect.
- States: IDLE, RUN.
- IDLE, accept, op ∈ {MULT, MULTU, DIV, DIVU}:
  - Compute the result from A/B and latch it into internal hi_tmp/lo_tmp. Latching captures the operands at issue.
  - Load counter=MUL_CYCLES (mult) or DIV_CYCLES (div); set busy=1; go to RUN.
- RUN, each edge: counter decrements.
  - When counter==1 at an edge: HI←hi_tmp, LO←lo_tmp, busy←0, go to IDLE.
  - busy is high for exactly N cycles after the issue edge.
  - The new HI/LO are visible in the first cycle with busy=0.
- IDLE, accept, op=MTHI: HI←A at that edge. op=MTLO: LO←A at that edge. busy stays 0.
- op=MFHI/MFLO: no state change.
- out = HI when op=MFHI, LO when op=MFLO, else 0.
  - out is independent of start/busy; the stall logic guarantees mf* is not in E while busy.
- Arithmetic:
  - MULT: signed 32×32→64; HI=upper 32 bits, LO=lower 32 bits. MULTU: unsigned.
  - DIV: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend. DIVU: unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B=0), DIV or DIVU:
  - Operation still runs DIV_CYCLES with busy=1.
  - At completion HI and LO keep their prior values.
- flush:
  - Suppresses acceptance in the same cycle only; no state change, HI/LO untouched.
  - An operation already in RUN is not cancelled; it was committed when it passed E.
- Simultaneous reset and start: reset wins.
- Undefined op values cannot occur because op is 3 bits and all 8 codes are defined.

Test Plan:
- reset; then MULT A=0xFFFFFFFF B=2 -> busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE, busy=0.
- MULTU A=0xFFFFFFFF B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE. Then op=MFLO -> out=0xFFFFFFFE.
- DIV A=0xFFFFFFF9 (-7) B=2 -> busy for exactly 10 cycles; HI/LO hold old values during busy; after: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MTHI A=0x12345678 -> HI=0x12345678 the next cycle, busy never asserts. Then DIVU A=7 B=0 -> busy 10 cycles; HI=0x12345678 and LO unchanged afterwards.
- MULT start with flush=1 -> busy stays 0, HI/LO unchanged. MULT issued, then a second start with A changed during busy -> the second start is ignored and the result uses the first operands.
- DIV started, reset asserted on the 4th busy cycle -> next cycle busy=0, HI=LO=0, and no late write follows.
